hart_mem_arbiter: RTL and testbench
===================================

# hart_mem_arbiter

Shares the hart's single memory port between the instruction-fetch requester and the load/store requester. It serialises the two request streams and drives one bus transaction at a time. It converts the load/store access width and byte offset into word-aligned byte enables and lane-shifted data, and rejects misaligned accesses. It sits between the hart core and the memory/bus interface and includes a watchdog for a stalled memory.

## Interface
- XLEN, 32 (from `isa_types`): address/data width.
- TIMEOUT_CYCLES, 255: number of BUSY cycles without `mem_ack` before the access is aborted; range 1..65535.

- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with `i_addr` until `i_ack`
- i_addr  in  XLEN  fetch byte address
- i_ack  out  1  one-cycle completion pulse for fetch
- i_err  out  1  valid with `i_ack`: misaligned or timed out
- i_rdata  out  XLEN  fetched word, valid with `i_ack`
- d_req  in  1  load/store request; payload held until `d_ack`
- d_we  in  1  1 = store, 0 = load
- d_width  in  write_width_t  byte / halfword / word
- d_addr  in  XLEN  data byte address
- d_wdata  in  XLEN  store data, right-aligned
- d_ack  out  1  one-cycle completion pulse for data
- d_err  out  1  valid with `d_ack`
- d_rdata  out  XLEN  load data, right-aligned, zero-extended
- mem_req  out  1  bus request; held until `mem_ack` or timeout
- mem_we  out  1  bus write
- mem_addr  out  XLEN  word address; bits [1:0] always 0
- mem_be  out  4  byte enables
- mem_wdata  out  XLEN  lane-positioned write data
- mem_ack  in  1  bus completion; `mem_rdata` valid in the same cycle
- mem_rdata  in  XLEN  bus read word

## Operation
- States:
  - IDLE: no access in progress.
  - BUSY: `mem_req` is high.
  - RESP: the requester ack pulse is driven.
- IDLE, no request pending: stay in IDLE.
- IDLE, request pending: select a grantee, register its payload, then:
  - aligned access: go to BUSY.
  - misaligned access: go to RESP with err=1 and rdata=0; no bus transaction is issued.
- Misaligned means any of:
  - `i_addr[1:0]` != 0.
  - halfword access with `d_addr[0]` = 1.
  - word access with `d_addr[1:0]` != 0.
- Fetches are always word reads with `mem_be` = 4'b1111.
- Byte access: `mem_be` = 1 << a[1:0]; `mem_wdata` = wdata[7:0] << 8·a[1:0].
- Halfword access: `mem_be` = a[1] ? 4'b1100 : 4'b0011; `mem_wdata` = wdata[15:0] << 16·a[1].
- Word access: `mem_be` = 4'b1111; `mem_wdata` = wdata.
- Load data: `d_rdata` = (`mem_rdata` >> 8·a[1:0]), masked to the access width; upper bits are zero. Sign extension is the requester's job.
- BUSY, `mem_ack` high: capture `mem_rdata`, clear the watchdog, go to RESP.
- BUSY, watchdog reaches TIMEOUT_CYCLES: drop `mem_req`, go to RESP with err=1 and rdata=0.
- RESP: pulse the grantee's ack (with its err and rdata) for exactly one cycle, then return to IDLE.
- `mem_ack` outside BUSY is ignored.
- Priority with both requests pending in IDLE: data wins; fetch waits.
- Requesters must deassert or renew `req` in the cycle after their ack. A req seen in IDLE is always treated as a new request.

## Timing
- Reset: state goes to IDLE asynchronously. All outputs are 0, the watchdog is 0, and the last-grant register is set to fetch.
- Bus latency L ≥ 1: request in cycle 0, `mem_req` high in cycles 1..L, `mem_ack` in cycle L, requester ack in cycle L+1.
- Throughput: at most one access per L+2 cycles.
- Misaligned access: ack in cycle 1; `mem_req` never rises.
- Timeout: `mem_req` high for TIMEOUT_CYCLES cycles, ack with err=1 in the following cycle.
- `mem_ack` and the timeout in the same cycle: `mem_ack` wins; err=0.
- `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` are registered and stable for the entire BUSY period. They are 0 outside BUSY.
- Reset asserted mid-access: the access is abandoned and no ack is issued. The memory side must tolerate `mem_req` dropping.

## Configuration
- `HART_MEM_ARB_RR_EN`, when defined: round-robin arbitration.
  - With both requests pending in IDLE, the grant goes to the requester not served last.
  - The last-grant register updates on every grant.
  - Because it resets to fetch, the first contention is won by data.
- When not defined: fixed data-over-fetch priority, and the last-grant register is not synthesised.

## Structure
- Add to the `isa_types` package:
  - `arb_state_t` enum {ARB_IDLE, ARB_BUSY, ARB_RESP}.
  - `arb_grant_t` enum {GRANT_FETCH, GRANT_DATA}.
- Reuse `write_width_t` and `XLEN` from `isa_types`.
- One combinational sub-module, `mem_lane_align`: computes the misaligned flag, `mem_be` and shifted write data from width/addr/wdata, plus load extraction from the read word. It is instantiated once.

## Test plan
- Word load, `d_addr`=0x104, L=1, `mem_rdata`=0xDEADBEEF → `mem_addr`=0x104, `mem_be`=1111 in cycle 1; `d_ack` with `d_rdata`=0xDEADBEEF in cycle 2.
- Byte store of 0xA5 at 0x203 → `mem_addr`=0x200, `mem_be`=1000, `mem_wdata`=0xA5000000, `mem_we`=1.
- Halfword load at 0x102, `mem_rdata`=0x1234ABCD → `mem_be`=1100, `d_rdata`=0x00001234.
- Halfword at 0x101 and fetch at 0x002 → each acked in cycle 1 with err=1; `mem_req` stays 0.
- `i_req` and `d_req` both held continuously:
  - without the macro: data is granted every time.
  - with `HART_MEM_ARB_RR_EN`: the grant order is data, fetch, data, fetch.
- TIMEOUT_CYCLES=4 with `mem_ack` never asserted → `mem_req` high 4 cycles, then `i_ack` with `i_err`=1. A `reset_n` pulse during BUSY clears all outputs immediately and no ack is issued.

Source files
------------

// File: rtl/isa_types.sv
// Shared ISA-level types: data width, access widths and memory-arbiter state/grant encodings.
package isa_types;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } write_width_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } arb_grant_t;

  // Request payload of whichever requester is being granted
  typedef struct packed {
    logic             we;
    write_width_t     width;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
  } arb_payload_t;

endpackage

// File: rtl/hart_mem_arbiter_if.sv
// Fetch, load/store and memory-bus handshake bundle for hart_mem_arbiter.
// slave = arbiter view; master = core + memory side view.
interface hart_mem_arbiter_if;
  import isa_types::*;

  logic             i_req;
  logic [XLEN-1:0]  i_addr;
  logic             i_ack;
  logic             i_err;
  logic [XLEN-1:0]  i_rdata;

  logic             d_req;
  logic             d_we;
  write_width_t     d_width;
  logic [XLEN-1:0]  d_addr;
  logic [XLEN-1:0]  d_wdata;
  logic             d_ack;
  logic             d_err;
  logic [XLEN-1:0]  d_rdata;

  logic             mem_req;
  logic             mem_we;
  logic [XLEN-1:0]  mem_addr;
  logic [3:0]       mem_be;
  logic [XLEN-1:0]  mem_wdata;
  logic             mem_ack;
  logic [XLEN-1:0]  mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_width, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_width, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: misalignment check, byte enables, write-data lane shift
// and right-aligned, zero-extended load extraction.
module mem_lane_align
  import isa_types::*;
(
  input  write_width_t     width,
  input  logic [1:0]       offset,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic             misaligned_c,
  output logic [3:0]       be_c,
  output logic [XLEN-1:0]  wdata_c,
  output logic [XLEN-1:0]  rdata_c
);
  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted      = rdata >> {offset, 3'b000};
    misaligned_c = 1'b0;
    be_c         = 4'b1111;
    wdata_c      = wdata;
    rdata_c      = shifted;
    case (width)
      WIDTH_BYTE: begin
        be_c    = 4'b0001 << offset;
        wdata_c = XLEN'(wdata[7:0]) << {offset, 3'b000};
        rdata_c = XLEN'(shifted[7:0]);
      end
      WIDTH_HALF: begin
        misaligned_c = offset[0];
        be_c         = offset[1] ? 4'b1100 : 4'b0011;
        wdata_c      = XLEN'(wdata[15:0]) << {offset[1], 4'b0000};
        rdata_c      = XLEN'(shifted[15:0]);
      end
      default: begin
        misaligned_c = (offset != 2'b00);
      end
    endcase
  end
endmodule

// File: rtl/hart_mem_arbiter.sv
// Serialises fetch and load/store requests onto the single memory port, with a stall watchdog.
// Define HART_MEM_ARB_RR_EN for round-robin arbitration (default: data over fetch).
module hart_mem_arbiter
  import isa_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clock,
  input logic               reset_n,
  hart_mem_arbiter_if.slave bus
);
  localparam int unsigned       WDOG_W    = 16;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  arb_state_t        state_q, state_d;
  arb_grant_t        grant_q, grant_d, sel_grant;
  write_width_t      width_q, width_d;
  logic [1:0]        off_q, off_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  arb_payload_t      sel_pay;

  logic              i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [XLEN-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;

  logic              resp_vld, resp_err;
  arb_grant_t        resp_grant;
  logic [XLEN-1:0]   resp_word, resp_lane;

  write_width_t      al_width;
  logic [1:0]        al_off;
  logic              al_mis;
  logic [3:0]        al_be;
  logic [XLEN-1:0]   al_wdata, al_rdata;

  // grant_q doubles as the last-grant record: it resets to fetch and updates on every grant
  always_comb begin
`ifdef HART_MEM_ARB_RR_EN
    if (bus.d_req && bus.i_req) begin
      sel_grant = (grant_q == GRANT_DATA) ? GRANT_FETCH : GRANT_DATA;
    end else begin
      sel_grant = bus.d_req ? GRANT_DATA : GRANT_FETCH;
    end
`else
    sel_grant = bus.d_req ? GRANT_DATA : GRANT_FETCH;
`endif
    if (sel_grant == GRANT_DATA) begin
      sel_pay = '{we: bus.d_we, width: bus.d_width, addr: bus.d_addr, wdata: bus.d_wdata};
    end else begin
      sel_pay = '{we: 1'b0, width: WIDTH_WORD, addr: bus.i_addr, wdata: XLEN'(0)};
    end
  end

  // Aligner sees the incoming payload in IDLE and the registered access afterwards
  assign al_width = (state_q == ARB_IDLE) ? sel_pay.width : width_q;
  assign al_off   = (state_q == ARB_IDLE) ? sel_pay.addr[1:0] : off_q;

  mem_lane_align u_align (
    .width        (al_width),
    .offset       (al_off),
    .wdata        (sel_pay.wdata),
    .rdata        (bus.mem_rdata),
    .misaligned_c (al_mis),
    .be_c         (al_be),
    .wdata_c      (al_wdata),
    .rdata_c      (al_rdata)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    width_d     = width_q;
    off_d       = off_q;
    wdog_d      = wdog_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_be_d    = '0;
    mem_wdata_d = '0;
    resp_vld    = 1'b0;
    resp_err    = 1'b0;
    resp_grant  = grant_q;
    resp_word   = '0;
    resp_lane   = '0;

    case (state_q)
      ARB_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          grant_d = sel_grant;
          width_d = sel_pay.width;
          off_d   = sel_pay.addr[1:0];
          if (al_mis) begin
            state_d    = ARB_RESP;
            resp_vld   = 1'b1;
            resp_err   = 1'b1;
            resp_grant = sel_grant;
          end else begin
            state_d     = ARB_BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = sel_pay.we;
            mem_addr_d  = {sel_pay.addr[XLEN-1:2], 2'b00};
            mem_be_d    = al_be;
            mem_wdata_d = al_wdata;
          end
        end
      end
      ARB_BUSY: begin
        if (bus.mem_ack) begin
          state_d   = ARB_RESP;
          wdog_d    = '0;
          resp_vld  = 1'b1;
          resp_word = bus.mem_rdata;
          resp_lane = al_rdata;
        end else if (wdog_q == WDOG_LAST) begin
          state_d  = ARB_RESP;
          wdog_d   = '0;
          resp_vld = 1'b1;
          resp_err = 1'b1;
        end else begin
          wdog_d      = wdog_q + WDOG_W'(1);
          mem_req_d   = 1'b1;
          mem_we_d    = mem_we_q;
          mem_addr_d  = mem_addr_q;
          mem_be_d    = mem_be_q;
          mem_wdata_d = mem_wdata_q;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase

    i_ack_d   = resp_vld && (resp_grant == GRANT_FETCH);
    d_ack_d   = resp_vld && (resp_grant == GRANT_DATA);
    i_err_d   = i_ack_d && resp_err;
    d_err_d   = d_ack_d && resp_err;
    i_rdata_d = i_ack_d ? resp_word : '0;
    d_rdata_d = d_ack_d ? resp_lane : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= GRANT_FETCH;
      width_q     <= WIDTH_BYTE;
      off_q       <= '0;
      wdog_q      <= '0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      width_q     <= width_d;
      off_q       <= off_d;
      wdog_q      <= wdog_d;
      i_ack_q     <= i_ack_d;
      i_err_q     <= i_err_d;
      i_rdata_q   <= i_rdata_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.i_ack     = i_ack_q;
  assign bus.i_err     = i_err_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Directed self-checking bench for hart_mem_arbiter (TIMEOUT_CYCLES = 4).
module tb_hart_mem_arbiter;
  import isa_types::*;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  hart_mem_arbiter_if bus ();

  hart_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_req   = 1'b0;
    bus.d_req   = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    logic exp_data;
    reset_n       = 1'b0;
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_width   = WIDTH_WORD;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    tick();
    tick();
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_be", 32'(bus.mem_be), 0);
    check("rst_acks", {30'd0, bus.i_ack, bus.d_ack}, 0);
    reset_n = 1'b1;
    tick();

    // Word load at 0x104, L=1
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_width = WIDTH_WORD; bus.d_addr = 32'h104;
    tick();
    check("wl_mem_req", 32'(bus.mem_req), 1);
    check("wl_mem_addr", bus.mem_addr, 32'h104);
    check("wl_mem_be", 32'(bus.mem_be), 32'hF);
    check("wl_mem_we", 32'(bus.mem_we), 0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    tick();
    check("wl_d_ack", {bus.d_ack, bus.d_err}, 32'b10);
    check("wl_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    check("wl_mem_req_drop", 32'(bus.mem_req), 0);
    check("wl_mem_addr_zero", bus.mem_addr, 0);
    idle_inputs();
    tick();
    check("wl_ack_pulse", 32'(bus.d_ack), 0);

    // Byte store of 0xA5 at 0x203, L=2
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_width = WIDTH_BYTE;
    bus.d_addr = 32'h203; bus.d_wdata = 32'h123456A5;
    tick();
    check("bs_mem_addr", bus.mem_addr, 32'h200);
    check("bs_mem_be", 32'(bus.mem_be), 32'h8);
    check("bs_mem_wdata", bus.mem_wdata, 32'hA5000000);
    check("bs_mem_we", 32'(bus.mem_we), 1);
    tick();
    check("bs_hold_req", 32'(bus.mem_req), 1);
    check("bs_hold_wdata", bus.mem_wdata, 32'hA5000000);
    bus.mem_ack = 1'b1;
    tick();
    check("bs_d_ack", {bus.d_ack, bus.d_err}, 32'b10);
    idle_inputs();
    tick();

    // Halfword load at 0x102
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_width = WIDTH_HALF; bus.d_addr = 32'h102;
    tick();
    check("hl_mem_addr", bus.mem_addr, 32'h100);
    check("hl_mem_be", 32'(bus.mem_be), 32'hC);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234ABCD;
    tick();
    check("hl_d_rdata", bus.d_rdata, 32'h00001234);
    idle_inputs();
    tick();

    // Byte load at 0x201
    bus.d_req = 1'b1; bus.d_width = WIDTH_BYTE; bus.d_addr = 32'h201;
    tick();
    check("bl_mem_be", 32'(bus.mem_be), 32'h2);
    bus.mem_ack = 1'b1;
    tick();
    check("bl_d_rdata", bus.d_rdata, 32'h000000AB);
    idle_inputs();
    tick();

    // Misaligned halfword at 0x101
    bus.d_req = 1'b1; bus.d_width = WIDTH_HALF; bus.d_addr = 32'h101;
    tick();
    check("mh_d_ack_err", {bus.d_ack, bus.d_err}, 32'b11);
    check("mh_d_rdata", bus.d_rdata, 0);
    check("mh_mem_req", 32'(bus.mem_req), 0);
    idle_inputs();
    tick();
    check("mh_mem_req_after", 32'(bus.mem_req), 0);

    // Misaligned fetch at 0x002
    bus.i_req = 1'b1; bus.i_addr = 32'h002;
    tick();
    check("mf_i_ack_err", {bus.i_ack, bus.i_err}, 32'b11);
    check("mf_i_rdata", bus.i_rdata, 0);
    check("mf_mem_req", 32'(bus.mem_req), 0);
    idle_inputs();
    tick();

    // Aligned fetch at 0x40
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    tick();
    check("af_mem_addr", bus.mem_addr, 32'h40);
    check("af_mem_be", 32'(bus.mem_be), 32'hF);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h00112233;
    tick();
    check("af_i_ack", {bus.i_ack, bus.i_err, bus.d_ack}, 32'b100);
    check("af_i_rdata", bus.i_rdata, 32'h00112233);
    idle_inputs();
    tick();

    // Contention: both requests held, memory always acking
    bus.i_req = 1'b1; bus.i_addr = 32'h80;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_width = WIDTH_WORD; bus.d_addr = 32'h300;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55AA55AA;
    for (int k = 0; k < 4; k++) begin
`ifdef HART_MEM_ARB_RR_EN
      exp_data = (k % 2 == 0);
`else
      exp_data = 1'b1;
`endif
      tick();
      check($sformatf("ct%0d_mem_addr", k), bus.mem_addr, exp_data ? 32'h300 : 32'h80);
      tick();
      check($sformatf("ct%0d_acks", k), {bus.d_ack, bus.i_ack}, exp_data ? 32'b10 : 32'b01);
      check($sformatf("ct%0d_rdata", k), exp_data ? bus.d_rdata : bus.i_rdata, 32'h55AA55AA);
      tick();
    end
    idle_inputs();
    tick();

    // Timeout: mem_ack never asserted
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("to_req_c%0d", c), {bus.mem_req, bus.i_ack}, 32'b10);
    end
    tick();
    check("to_i_ack_err", {bus.i_ack, bus.i_err}, 32'b11);
    check("to_i_rdata", bus.i_rdata, 0);
    check("to_mem_req", 32'(bus.mem_req), 0);
    idle_inputs();
    tick();

    // mem_ack in the same cycle the watchdog expires: ack wins
    bus.i_req = 1'b1; bus.i_addr = 32'h44;
    tick();
    tick();
    tick();
    tick();
    check("ta_req_c4", 32'(bus.mem_req), 1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    tick();
    check("ta_i_ack_err", {bus.i_ack, bus.i_err}, 32'b10);
    check("ta_i_rdata", bus.i_rdata, 32'hCAFEF00D);
    idle_inputs();
    tick();

    // Reset pulse during BUSY
    bus.i_req = 1'b1; bus.i_addr = 32'h48;
    tick();
    check("rb_busy", 32'(bus.mem_req), 1);
    reset_n = 1'b0;
    #1;
    check("rb_mem_req", 32'(bus.mem_req), 0);
    check("rb_mem_addr", bus.mem_addr, 0);
    check("rb_mem_be", 32'(bus.mem_be), 0);
    idle_inputs();
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("rb_no_ack%0d", c), {bus.i_ack, bus.d_ack, bus.mem_req}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
